// File: rtl/object_spawn_sequencer.sv
// Object spawn sequencer: walks the stage pattern ROM, waits each entry's centisecond delay and offers one object per entry.
// Optional SPAWN_ACK_TIMEOUT_EN abandons a stalled handshake after ACK_TIMEOUT cycles and raises sticky timeout_err.
module object_spawn_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int PATTERN_LEN = 16,
  parameter int ACK_TIMEOUT = 1023
) (
  input  logic              clk_calculation,
  input  logic              reset,
  input  logic              start,
  input  logic              pause,
  input  logic              clk_centi_second,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [71:0]       rom_data,
  output logic [2:0]        object_movement_direction,
  output logic [9:0]        object_pos_x,
  output logic [9:0]        object_pos_y,
  output logic [9:0]        object_w,
  output logic [9:0]        object_h,
  output logic [4:0]        object_speed,
  output logic [7:0]        object_destroy_time,
  output logic [1:0]        object_destroy_trigger,
  output logic              sync_object_position,
  input  logic              update_object_position,
  output logic              busy,
  output logic              done,
  output logic [7:0]        spawn_count,
  output logic              timeout_err
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PATTERN_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_DELAY, S_PRESENT, S_RELEASE, S_NEXT
  } state_t;

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_delay;
  logic [7:0]        r_count;
  logic [57:0]       r_obj;
  logic              r_done;
  logic              r_cs_meta, r_cs_sync, r_cs_prev;
  logic              w_tick;
  logic              w_timeout;
  logic [4:0]        w_unused_rsvd;

  assign w_unused_rsvd = rom_data[4:0];
  assign w_tick        = r_cs_sync & ~r_cs_prev;

`ifdef SPAWN_ACK_TIMEOUT_EN
  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
  logic [TO_W-1:0] r_to_cnt;
  logic            r_to_err;
  logic            w_in_hs;

  assign w_in_hs = (r_state == S_PRESENT) || (r_state == S_RELEASE);
  // A handshake step completing on the last cycle beats the timeout.
  assign w_timeout = w_in_hs && (r_to_cnt == TO_W'(ACK_TIMEOUT - 1)) &&
                     !((r_state == S_PRESENT) ? update_object_position : !update_object_position);
  assign timeout_err = r_to_err;

  always_ff @(posedge clk_calculation) begin
    if (reset) begin
      r_to_cnt <= '0;
      r_to_err <= 1'b0;
    end else begin
      r_to_cnt <= w_in_hs ? r_to_cnt + 1'b1 : '0;
      if (w_timeout) r_to_err <= 1'b1;
    end
  end
`else
  logic w_unused_to;
  assign w_unused_to = (ACK_TIMEOUT > 0);
  assign w_timeout   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = S_FETCH;
      S_FETCH:   w_next = S_LOAD;
      S_LOAD: begin
        if (rom_data[71])              w_next = S_IDLE;
        else if (rom_data[70:63] == 0) w_next = S_PRESENT;
        else                           w_next = S_DELAY;
      end
      S_DELAY:   if (w_tick && !pause && r_delay == 8'd1) w_next = S_PRESENT;
      S_PRESENT: begin
        if (update_object_position) w_next = S_RELEASE;
        else if (w_timeout)         w_next = S_NEXT;
      end
      S_RELEASE: if (!update_object_position || w_timeout) w_next = S_NEXT;
      S_NEXT:    w_next = (r_addr == LAST_ADDR) ? S_IDLE : S_FETCH;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_calculation) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_delay   <= '0;
      r_count   <= '0;
      r_obj     <= '0;
      r_done    <= 1'b0;
      r_cs_meta <= 1'b0;
      r_cs_sync <= 1'b0;
      r_cs_prev <= 1'b0;
    end else begin
      r_cs_meta <= clk_centi_second;
      r_cs_sync <= r_cs_meta;
      r_cs_prev <= r_cs_sync;
      r_state   <= w_next;
      r_done    <= (w_next == S_IDLE) && (r_state != S_IDLE);
      case (r_state)
        S_IDLE: if (start) begin
          r_addr  <= '0;
          r_count <= '0;
        end
        S_LOAD: begin
          r_obj   <= rom_data[62:5];
          r_delay <= rom_data[70:63];
        end
        S_DELAY:   if (w_tick && !pause) r_delay <= r_delay - 8'd1;
        S_PRESENT: if (update_object_position && r_count != 8'hFF) r_count <= r_count + 8'd1;
        S_NEXT:    if (r_addr != LAST_ADDR) r_addr <= r_addr + 1'b1;
        default: ;
      endcase
    end
  end

  assign rom_addr                  = r_addr;
  assign object_movement_direction = r_obj[57:55];
  assign object_pos_x              = r_obj[54:45];
  assign object_pos_y              = r_obj[44:35];
  assign object_w                  = r_obj[34:25];
  assign object_h                  = r_obj[24:15];
  assign object_speed              = r_obj[14:10];
  assign object_destroy_time       = r_obj[9:2];
  assign object_destroy_trigger    = r_obj[1:0];
  assign sync_object_position      = (r_state != S_PRESENT);
  assign busy                      = (r_state != S_IDLE);
  assign done                      = r_done;
  assign spawn_count               = r_count;
endmodule

// File: tb/tb_object_spawn_sequencer.sv
// Bench for object_spawn_sequencer: ROM model, receiver model, and a field scoreboard filled at stimulus time.
`timescale 1ns/1ps
module tb_object_spawn_sequencer;
  localparam int ADDR_W = 8;
  localparam int PLEN   = 4;
  localparam int ACK_TO = 10;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, pause = 1'b0, cs = 1'b0, update = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  logic [71:0] rom_data;
  logic [2:0] dir;
  logic [9:0] px, py, ow, oh;
  logic [4:0] spd;
  logic [7:0] dtime, spawn_count;
  logic [1:0] trg;
  logic sync, busy, done, timeout_err;

  logic [71:0] rom [0:3];
  logic [57:0] exp_q[$], got_q[$];
  int checks = 0, failures = 0, cyc = 0;
  int rx_lat = 2, rx_hold = 0, rx_cnt = 0;
  bit rx_never = 0;
  int unstable = 0, overlap = 0, max_addr = 0, n_lows = 0;
  int low_first = -1, low_pulses = -1, n_pulses = 0, rise_cyc = 0;
  logic prev_sync = 1'b1;
  logic [57:0] low_fields = '0;
  wire [57:0] fields = {dir, px, py, ow, oh, spd, dtime, trg};

  object_spawn_sequencer #(.ADDR_W(ADDR_W), .PATTERN_LEN(PLEN), .ACK_TIMEOUT(ACK_TO)) dut (
    .clk_calculation(clk), .reset(reset), .start(start), .pause(pause), .clk_centi_second(cs),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .object_movement_direction(dir), .object_pos_x(px), .object_pos_y(py), .object_w(ow), .object_h(oh),
    .object_speed(spd), .object_destroy_time(dtime), .object_destroy_trigger(trg),
    .sync_object_position(sync), .update_object_position(update),
    .busy(busy), .done(done), .spawn_count(spawn_count), .timeout_err(timeout_err));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rom_data <= rom[rom_addr[1:0]];
  end

  // Receiver: acks rx_lat cycles after sync drops, holds update rx_hold extra cycles after release.
  always @(negedge clk) begin
    if (int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
    if (!sync && prev_sync) begin
      n_lows++;
      low_fields = fields;
      if (low_first < 0) begin low_first = cyc; low_pulses = n_pulses; end
    end
    prev_sync = sync;
    if (reset) begin
      update = 1'b0; rx_cnt = 0;
    end else if (!update) begin
      if (!sync) begin
        if (fields !== low_fields) unstable++;
        rx_cnt++;
        if (rx_cnt >= rx_lat && !rx_never) begin
          got_q.push_back(fields); update = 1'b1; rx_cnt = 0;
        end
      end else rx_cnt = 0;
    end else begin
      if (fields !== low_fields) unstable++;
      if (!sync) overlap++;
      else begin
        rx_cnt++;
        if (rx_cnt > rx_hold) begin update = 1'b0; rx_cnt = 0; end
      end
    end
  end

  function automatic logic [71:0] mk(input logic e, input logic [7:0] d, input int s);
    return {e, d, 3'(s), 10'(s*37+5), 10'(s*53+9), 10'(s*11+100), 10'(s*7+200),
            5'(s+3), 8'(s*13+1), 2'(s), 5'h1B};
  endfunction

  task automatic do_start(output int s_cyc);
    @(negedge clk); start = 1'b1; s_cyc = cyc;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int max, output bit seen, output bit one_cycle);
    seen = 0; one_cycle = 0;
    for (int i = 0; i < max && !seen; i++) begin @(negedge clk); if (done) seen = 1; end
    if (seen) begin @(negedge clk); one_cycle = !done; end
  endtask

  task automatic centi_pulse();
    @(negedge clk); cs = 1'b1; n_pulses++; rise_cyc = cyc;
    repeat (4) @(negedge clk);
    cs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (sync !== 1'b1) begin failures++; $display("FAIL rst_sync got=%b exp=1", sync); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rst_busy_done got=%b%b exp=00", busy, done); end
    checks++; if (spawn_count !== 8'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", spawn_count); end
    checks++; if (rom_addr !== '0) begin failures++; $display("FAIL rst_addr got=%0d exp=0", rom_addr); end
    checks++; if (fields !== 58'd0) begin failures++; $display("FAIL rst_fields got=%h exp=0", fields); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL rst_timeout got=%b exp=0", timeout_err); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_basic();
    int s_cyc; bit seen, one; logic [57:0] e, g;
    rom[0] = mk(0, 0, 1); rom[1] = mk(0, 0, 2); rom[2] = mk(1, 0, 3); rom[3] = mk(0, 0, 4);
    exp_q.push_back(rom[0][62:5]); exp_q.push_back(rom[1][62:5]);
    low_first = -1; unstable = 0;
    do_start(s_cyc);
    wait_done(300, seen, one);
    checks++; if (!seen || !one) begin failures++; $display("FAIL basic_done seen=%b pulse1=%b exp=11", seen, one); end
    checks++; if (low_first - s_cyc != 3) begin failures++; $display("FAIL basic_latency got=%0d exp=3", low_first - s_cyc); end
    checks++; if (spawn_count !== 8'd2) begin failures++; $display("FAIL basic_count got=%0d exp=2", spawn_count); end
    checks++; if (unstable != 0) begin failures++; $display("FAIL basic_stable got=%0d exp=0", unstable); end
    checks++; if (got_q.size() != 2) begin failures++; $display("FAIL basic_spawns got=%0d exp=2", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin failures++; $display("FAIL basic_fields got=%h exp=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_delay_pause();
    int s_cyc; bit seen, one; logic [57:0] e, g;
    rom[0] = mk(0, 5, 5); rom[1] = mk(1, 0, 6);
    exp_q.push_back(rom[0][62:5]);
    low_first = -1; n_pulses = 0;
    do_start(s_cyc);
    repeat (3) @(negedge clk);
    for (int p = 1; p <= 8; p++) begin
      if (p == 3) pause = 1'b1;
      centi_pulse();
      if (p == 5) pause = 1'b0;
    end
    checks++; if (low_pulses != 8) begin failures++; $display("FAIL delay_ticks got=%0d exp=8", low_pulses); end
    checks++; if (low_first - rise_cyc != 3) begin failures++; $display("FAIL delay_latency got=%0d exp=3", low_first - rise_cyc); end
    wait_done(200, seen, one);
    checks++; if (!seen || spawn_count !== 8'd1) begin failures++; $display("FAIL delay_done seen=%b count=%0d exp=1/1", seen, spawn_count); end
    checks++; if (got_q.size() != 1) begin failures++; $display("FAIL delay_spawns got=%0d exp=1", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin failures++; $display("FAIL delay_fields got=%h exp=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_hold();
    int s_cyc; bit seen, one; logic [57:0] e, g;
    rom[0] = mk(0, 0, 7); rom[1] = mk(0, 0, 8); rom[2] = mk(1, 0, 9);
    exp_q.push_back(rom[0][62:5]); exp_q.push_back(rom[1][62:5]);
    rx_hold = 4; overlap = 0;
    do_start(s_cyc);
    wait_done(300, seen, one);
    rx_hold = 0;
    checks++; if (overlap != 0) begin failures++; $display("FAIL hold_overlap got=%0d exp=0", overlap); end
    checks++; if (!seen || spawn_count !== 8'd2) begin failures++; $display("FAIL hold_count seen=%b got=%0d exp=2", seen, spawn_count); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin failures++; $display("FAIL hold_fields got=%h exp=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_len();
    int s_cyc; bit seen, one; logic [57:0] e, g;
    for (int i = 0; i < 4; i++) begin rom[i] = mk(0, 0, 10 + i); exp_q.push_back(rom[i][62:5]); end
    max_addr = 0;
    do_start(s_cyc);
    wait_done(400, seen, one);
    checks++; if (!seen || !one) begin failures++; $display("FAIL len_done seen=%b pulse1=%b exp=11", seen, one); end
    checks++; if (spawn_count !== 8'd4) begin failures++; $display("FAIL len_count got=%0d exp=4", spawn_count); end
    checks++; if (max_addr != 3) begin failures++; $display("FAIL len_max_addr got=%0d exp=3", max_addr); end
    checks++; if (got_q.size() != 4) begin failures++; $display("FAIL len_spawns got=%0d exp=4", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin failures++; $display("FAIL len_fields got=%h exp=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_mid();
    int s_cyc, base; bit seen, one; logic [57:0] e, g;
    rom[0] = mk(0, 0, 20); rom[1] = mk(0, 0, 21); rom[2] = mk(1, 0, 22);
    exp_q.push_back(rom[0][62:5]);
    base = n_lows;
    do_start(s_cyc);
    for (int i = 0; i < 200 && got_q.size() < 1; i++) @(negedge clk);
    rx_never = 1;
    for (int i = 0; i < 200 && n_lows < base + 2; i++) @(negedge clk);
    checks++; if (sync !== 1'b0 || spawn_count !== 8'd1) begin failures++; $display("FAIL mid_pre sync=%b count=%0d exp=0/1", sync, spawn_count); end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (sync !== 1'b1) begin failures++; $display("FAIL mid_sync got=%b exp=1", sync); end
    checks++; if (spawn_count !== 8'd0 || busy !== 1'b0) begin failures++; $display("FAIL mid_state count=%0d busy=%b exp=0/0", spawn_count, busy); end
    @(negedge clk); reset = 1'b0; rx_never = 0;
    exp_q.push_back(rom[0][62:5]); exp_q.push_back(rom[1][62:5]);
    do_start(s_cyc);
    wait_done(300, seen, one);
    checks++; if (!seen || spawn_count !== 8'd2) begin failures++; $display("FAIL mid_replay seen=%b count=%0d exp=2", seen, spawn_count); end
    checks++; if (got_q.size() != 3) begin failures++; $display("FAIL mid_spawns got=%0d exp=3", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin failures++; $display("FAIL mid_fields got=%h exp=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

`ifdef SPAWN_ACK_TIMEOUT_EN
  task automatic test_timeout();
    int s_cyc, err_cyc; bit seen, one; logic [57:0] e, g;
    rom[0] = mk(0, 0, 30); rom[1] = mk(0, 0, 31); rom[2] = mk(1, 0, 32);
    exp_q.push_back(rom[1][62:5]);
    rx_never = 1; low_first = -1; err_cyc = -1;
    do_start(s_cyc);
    for (int i = 0; i < 100 && err_cyc < 0; i++) begin @(negedge clk); if (timeout_err) err_cyc = cyc; end
    checks++; if (err_cyc - low_first != ACK_TO) begin failures++; $display("FAIL to_cycles got=%0d exp=%0d", err_cyc - low_first, ACK_TO); end
    checks++; if (sync !== 1'b1 || spawn_count !== 8'd0) begin failures++; $display("FAIL to_state sync=%b count=%0d exp=1/0", sync, spawn_count); end
    rx_never = 0;
    wait_done(300, seen, one);
    checks++; if (!seen || spawn_count !== 8'd1 || timeout_err !== 1'b1) begin failures++; $display("FAIL to_after seen=%b count=%0d err=%b exp=1/1/1", seen, spawn_count, timeout_err); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin failures++; $display("FAIL to_fields got=%h exp=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask
`else
  task automatic test_timeout();
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL to_tied got=%b exp=0", timeout_err); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 4; i++) rom[i] = '0;
    test_reset();
    test_basic();
    test_delay_pause();
    test_hold();
    test_len();
    test_reset_mid();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
